// File: rtl/mem_access_stage_if.sv
// EX/SRAM-to-MEM inputs and MEM-to-ID/WB outputs of the memory-access stage.
// master drives EX payload, control and SRAM response; slave is the stage itself.
interface mem_access_stage_if #(
    parameter int PC_W  = 32,
    parameter int RF_AW = 5
);
    logic             stall_i;
    logic             flush_i;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_ld;
    logic [1:0]       ex_ld_size;
    logic             ex_ld_uns;
    logic [1:0]       ex_addr_lo;
    logic             ex_rf_we;
    logic [RF_AW-1:0] ex_rf_waddr;
    logic [31:0]      ex_result;
    logic [31:0]      data_sram_rdata;
    logic             data_sram_rvalid;
    logic             mem_stall_req;
    logic             fwd_we;
    logic [RF_AW-1:0] fwd_waddr;
    logic [31:0]      fwd_wdata;
    logic             fwd_pending;
    logic             wb_valid;
    logic [PC_W-1:0]  wb_pc;
    logic             wb_rf_we;
    logic [RF_AW-1:0] wb_rf_waddr;
    logic [31:0]      wb_rf_wdata;
    logic             mem_timeout_err;

    modport master (
        output stall_i, flush_i, ex_valid, ex_pc, ex_ld, ex_ld_size, ex_ld_uns, ex_addr_lo,
               ex_rf_we, ex_rf_waddr, ex_result, data_sram_rdata, data_sram_rvalid,
        input  mem_stall_req, fwd_we, fwd_waddr, fwd_wdata, fwd_pending, wb_valid, wb_pc,
               wb_rf_we, wb_rf_waddr, wb_rf_wdata, mem_timeout_err
    );

    modport slave (
        input  stall_i, flush_i, ex_valid, ex_pc, ex_ld, ex_ld_size, ex_ld_uns, ex_addr_lo,
               ex_rf_we, ex_rf_waddr, ex_result, data_sram_rdata, data_sram_rvalid,
        output mem_stall_req, fwd_we, fwd_waddr, fwd_wdata, fwd_pending, wb_valid, wb_pc,
               wb_rf_we, wb_rf_waddr, wb_rf_wdata, mem_timeout_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: variable-latency load handshake, sub-word extension, ID bypass, flush drain, load watchdog.
// Latency: 1 cycle EX->WB when data is ready; loads stall (mem_stall_req) until rvalid or timeout.
module mem_access_stage #(
    parameter int PC_W        = 32,
    parameter int RF_AW       = 5,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        logic             ld;
        logic [1:0]       ld_size;
        logic             ld_uns;
        logic [1:0]       addr_lo;
        logic             rf_we;
        logic [RF_AW-1:0] rf_waddr;
        logic [31:0]      result;
    } stage_t;

    stage_t           stage_q, stage_d, ex_pay;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic        rvalid, ld_cyc, tmo_hit, stall_req;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, wdata;

    assign rvalid = bus.data_sram_rvalid;

    always_comb begin
        ex_pay          = '0;
        ex_pay.valid    = bus.ex_valid;
        ex_pay.pc       = bus.ex_pc;
        ex_pay.ld       = bus.ex_ld;
        ex_pay.ld_size  = bus.ex_ld_size;
        ex_pay.ld_uns   = bus.ex_ld_uns;
        ex_pay.addr_lo  = bus.ex_addr_lo;
        ex_pay.rf_we    = bus.ex_rf_we;
        ex_pay.rf_waddr = bus.ex_rf_waddr;
        ex_pay.result   = bus.ex_result;
    end

    // A load sitting in MEM during DRAIN is not yet live: the pending response belongs to the flushed load.
    always_comb begin
        ld_cyc    = stage_q.valid & stage_q.ld & (state_q != S_DRAIN);
        tmo_hit   = (state_q == S_WAIT) & ~rvalid & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        stall_req = 1'b0;
        case (state_q)
            S_IDLE:  stall_req = ld_cyc & ~rvalid;
            S_WAIT:  stall_req = ~rvalid & ~tmo_hit;
            S_DRAIN: stall_req = stage_q.valid & stage_q.ld;
            default: stall_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (ld_cyc & ~rvalid) begin
                    state_d = bus.flush_i ? S_DRAIN : S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (rvalid) begin
                    state_d = S_IDLE;
                end else if (bus.flush_i) begin
                    state_d = S_DRAIN;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (bus.flush_i)     stage_d = '0;
        else if (stall_req)  stage_d = stage_q;
        else if (bus.stall_i) stage_d = '0;
        else                 stage_d = ex_pay;
    end

    // Half lane selected by addr_lo[1] only; misaligned halves never reach this stage.
    always_comb begin
        case (stage_q.addr_lo)
            2'd0:    ld_byte = bus.data_sram_rdata[7:0];
            2'd1:    ld_byte = bus.data_sram_rdata[15:8];
            2'd2:    ld_byte = bus.data_sram_rdata[23:16];
            default: ld_byte = bus.data_sram_rdata[31:24];
        endcase
        ld_half = stage_q.addr_lo[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
        case (stage_q.ld_size)
            2'b00:   ld_ext = {{24{~stage_q.ld_uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~stage_q.ld_uns & ld_half[15]}}, ld_half};
            default: ld_ext = bus.data_sram_rdata;
        endcase
        wdata = stage_q.ld ? ld_ext : stage_q.result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_stall_req   = stall_req;
    assign bus.fwd_we          = stage_q.valid & stage_q.rf_we;
    assign bus.fwd_waddr       = stage_q.rf_waddr;
    assign bus.fwd_wdata       = wdata;
    assign bus.fwd_pending     = stage_q.valid & stage_q.ld & ~((state_q != S_DRAIN) & rvalid);
    assign bus.wb_valid        = stage_q.valid & ~stall_req;
    assign bus.wb_pc           = stage_q.pc;
    assign bus.wb_rf_we        = stage_q.rf_we & ~tmo_hit;
    assign bus.wb_rf_waddr     = stage_q.rf_waddr;
    assign bus.wb_rf_wdata     = wdata;
    assign bus.mem_timeout_err = err_q;
endmodule
